// File: rtl/dap_bridge.sv
// dap_bridge: AVR 8-bit strobed bus to single-word read/write request bridge.
// Latency: request raised ~3 clk after the final byte strobe (sync + edge detect); read bytes drive combinationally.
// Backpressure: request held with dap_r_n_b low until rq_ack; a timeout drops it, sets err and returns to IDLE.
module dap_bridge #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire  [7:0]        dap_data,
  input  logic              dap_ce_n,
  input  logic              dap_we_n,
  input  logic              dap_re_n,
  output logic              dap_r_n_b,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] d_wr,
  input  logic [DATA_W-1:0] d_rd,
  output logic              w_rq,
  output logic              r_rq,
  input  logic              rq_ack,
  output logic              err
);

  localparam int AB = (ADDR_W + 7) / 8;
  localparam int DB = DATA_W / 8;
  localparam logic [2:0] AB_LAST = 3'(AB - 1);
  localparam logic [2:0] DB_LAST = 3'(DB - 1);
  // Last counter value before the request has been high for 2^TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDAT, S_WREQ, S_RREQ, S_RDAT
  } state_t;

  state_t state, state_nxt;

  // [0] stage 1, [1] stage 2 (synchronized value), [2] stage 3 (edge reference)
  logic [2:0] ce_sync, we_sync, re_sync;
  logic [7:0] dat_s1, dat_s2;

  logic [2:0]        bcnt;
  logic [2:0]        ridx;
  logic              is_rd, auto_inc;
  logic [DATA_W-1:0] rbuf;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [AB*8-1:0]   addr_ext;
  logic              rd_oe;

  logic ce_s2, ce_fall, we_rise, re_rise, req_st, tmo_hit;

  assign ce_s2   = ce_sync[1];
  assign ce_fall = ~ce_sync[1] & ce_sync[2];
  assign we_rise = we_sync[1] & ~we_sync[2];
  assign re_rise = re_sync[1] & ~re_sync[2];
  assign req_st  = (state == S_WREQ) || (state == S_RREQ);
  // An ack in the terminal cycle wins over the timeout.
  assign tmo_hit = req_st && !ce_s2 && !rq_ack && (tmo_cnt == TMO_LAST);

  // Bring the asynchronous AVR pins into the clk domain; reset to an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_sync <= '1;
      we_sync <= '1;
      re_sync <= '1;
      dat_s1  <= '1;
      dat_s2  <= '1;
    end else begin
      ce_sync <= {ce_sync[1:0], dap_ce_n};
      we_sync <= {we_sync[1:0], dap_we_n};
      re_sync <= {re_sync[1:0], dap_re_n};
      dat_s1  <= dap_data;
      dat_s2  <= dat_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a deselected chip always returns to IDLE.
  always_comb begin
    state_nxt = state;
    if (ce_s2) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (ce_fall) state_nxt = S_CMD;
        S_CMD:  if (we_rise) state_nxt = S_ADDR;
        S_ADDR: if (we_rise && bcnt == AB_LAST) state_nxt = is_rd ? S_RREQ : S_WDAT;
        S_WDAT: if (we_rise && bcnt == DB_LAST) state_nxt = S_WREQ;
        S_WREQ: begin
          if (rq_ack)       state_nxt = S_WDAT;
          else if (tmo_hit) state_nxt = S_IDLE;
        end
        S_RREQ: begin
          if (rq_ack)       state_nxt = S_RDAT;
          else if (tmo_hit) state_nxt = S_IDLE;
        end
        S_RDAT: if (re_rise && ridx == DB_LAST && auto_inc) state_nxt = S_RREQ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state; read data gated by the raw pins so it tracks the strobe directly.
  always_comb begin
    w_rq      = (state == S_WREQ);
    r_rq      = (state == S_RREQ);
    dap_r_n_b = !((state == S_WREQ) || (state == S_RREQ));
    rd_oe     = (state == S_RDAT) && !dap_ce_n && !dap_re_n;
  end

  assign dap_data = rd_oe ? rbuf[{ridx, 3'b000} +: 8] : 8'bz;

  // Insert the incoming address byte at its position; bits above ADDR_W fall away.
  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_W-1:0] = addr;
    addr_ext[{bcnt, 3'b000} +: 8] = dat_s2;
  end

  // Byte-level datapath: command flags, address/data assembly, read buffer, timeout and error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      d_wr     <= '0;
      rbuf     <= '0;
      bcnt     <= '0;
      ridx     <= '0;
      is_rd    <= 1'b0;
      auto_inc <= 1'b0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      tmo_cnt <= req_st ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) err <= 1'b1;
      if (!ce_s2) begin
        case (state)
          S_IDLE: bcnt <= '0;
          S_CMD: begin
            if (we_rise) begin
              is_rd    <= dat_s2[0];
              auto_inc <= dat_s2[1];
              bcnt     <= '0;
            end
          end
          S_ADDR: begin
            if (we_rise) begin
              addr <= addr_ext[ADDR_W-1:0];
              bcnt <= (bcnt == AB_LAST) ? 3'd0 : bcnt + 1'b1;
            end
          end
          S_WDAT: begin
            if (we_rise) begin
              d_wr[{bcnt, 3'b000} +: 8] <= dat_s2;
              bcnt <= (bcnt == DB_LAST) ? 3'd0 : bcnt + 1'b1;
            end
          end
          S_WREQ: begin
            if (rq_ack && auto_inc) addr <= addr + 1'b1;
          end
          S_RREQ: begin
            if (rq_ack) begin
              rbuf <= d_rd;
              ridx <= '0;
            end
          end
          S_RDAT: begin
            if (re_rise) begin
              if (ridx == DB_LAST) begin
                ridx <= '0;
                if (auto_inc) addr <= addr + 1'b1;
              end else begin
                ridx <= ridx + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dap_bridge.sv
// tb_dap_bridge: drives AVR byte transactions and a target model, checks requests and read bytes.
// Expected requests come from a transaction-level model (address sequence, word values, read function).
// The target acks after a programmable delay and may pulse rq_ack while idle.
module tb_dap_bridge;

  localparam int AW      = 24;
  localparam int DW      = 16;
  localparam int TW      = 8;
  localparam int TMO_CYC = (1 << TW) - 1;

  typedef struct {
    bit          wr;
    bit          to;
    logic [23:0] a;
    logic [15:0] d;
    int          cyc;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic          dap_ce_n, dap_we_n, dap_re_n;
  wire  [7:0]    dap_data;
  logic          dap_r_n_b;
  logic [AW-1:0] addr;
  logic [DW-1:0] d_wr;
  logic [DW-1:0] d_rd;
  logic          w_rq, r_rq, rq_ack, err;

  logic [7:0] tb_dat;
  logic       tb_oe;
  assign dap_data = tb_oe ? tb_dat : 8'bz;

  int  n_chk, n_err;
  ev_t ev_q[$];
  ev_t exp_q[$];

  int          hi_cnt, ack_delay, stab_bad, rnb_bad;
  bit          ack_tied, rand_dly, cur_wr;
  logic [23:0] st_a;
  logic [15:0] st_d;

  dap_bridge #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .dap_data(dap_data), .dap_ce_n(dap_ce_n),
    .dap_we_n(dap_we_n), .dap_re_n(dap_re_n), .dap_r_n_b(dap_r_n_b),
    .addr(addr), .d_wr(d_wr), .d_rd(d_rd), .w_rq(w_rq), .r_rq(r_rq),
    .rq_ack(rq_ack), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Target read data as a function of address; 0x000100 returns 0xBEEF.
  function automatic logic [15:0] rd_fn(input logic [23:0] a);
    logic [23:0] t;
    t = a - 24'h000100;
    return 16'hBEEF ^ 16'(t * 24'h009E37);
  endfunction

  // Target and request monitor: observe at negedge, then set rq_ack/d_rd for the next edge.
  initial begin
    hi_cnt = 0; stab_bad = 0; rnb_bad = 0; cur_wr = 1'b0;
    rq_ack = 1'b0; d_rd = '0;
    forever begin
      @(negedge clk);
      if (w_rq || r_rq) begin
        if (hi_cnt == 0) begin
          st_a = addr; st_d = d_wr; cur_wr = w_rq;
        end else if (addr !== st_a || d_wr !== st_d) begin
          stab_bad++;
        end
        if (dap_r_n_b !== 1'b0 || (w_rq && r_rq)) rnb_bad++;
        rq_ack = (hi_cnt >= ack_delay);
        d_rd   = (rq_ack && r_rq) ? rd_fn(addr) : 16'($urandom);
        hi_cnt++;
        if (rq_ack) begin
          ev_t e;
          e.wr = cur_wr; e.to = 1'b0; e.a = st_a; e.d = st_d; e.cyc = hi_cnt;
          ev_q.push_back(e);
          hi_cnt = 0;
          if (rand_dly) ack_delay = $urandom_range(0, 4);
        end
      end else begin
        if (dap_r_n_b !== 1'b1) rnb_bad++;
        if (hi_cnt > 0) begin
          ev_t e;
          e.wr = cur_wr; e.to = 1'b1; e.a = st_a; e.d = st_d; e.cyc = hi_cnt;
          ev_q.push_back(e);
          hi_cnt = 0;
        end
        rq_ack = ack_tied ? 1'b1 : 1'($urandom_range(0, 1));
        d_rd   = 16'($urandom);
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic avr_wr(input logic [7:0] b);
    tb_dat = b; tb_oe = 1'b1;
    wclk(1);
    dap_we_n = 1'b0; wclk(4);
    dap_we_n = 1'b1; wclk(4);
    tb_oe = 1'b0;
  endtask

  task automatic avr_rd(output logic [7:0] b);
    dap_re_n = 1'b0; wclk(3);
    b = dap_data;
    dap_re_n = 1'b1; wclk(4);
  endtask

  task automatic ce_lo();
    dap_ce_n = 1'b0; wclk(4);
  endtask

  task automatic ce_hi();
    dap_ce_n = 1'b1; wclk(4);
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (dap_r_n_b !== 1'b1 && n < 200) begin
      wclk(1);
      n++;
    end
    chk_val({tag, "_rdy"}, 32'(dap_r_n_b), 32'd1);
  endtask

  task automatic exp_push(input bit wr, input bit to, input logic [23:0] a,
                          input logic [15:0] d, input int cyc);
    ev_t e;
    e.wr = wr; e.to = to; e.a = a; e.d = d; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic cmp_ev(input string tag);
    ev_t e, x;
    wclk(2);
    chk_val({tag, "_nreq"}, 32'(ev_q.size()), 32'(exp_q.size()));
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      e = ev_q.pop_front();
      x = exp_q.pop_front();
      chk_val({tag, "_kind"}, {30'd0, e.wr, e.to}, {30'd0, x.wr, x.to});
      chk_val({tag, "_addr"}, 32'(e.a), 32'(x.a));
      if (x.wr) chk_val({tag, "_data"}, 32'(e.d), 32'(x.d));
      if (x.cyc != 0) chk_val({tag, "_cyc"}, 32'(e.cyc), 32'(x.cyc));
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic send_hdr(input bit rd, input bit inc, input logic [23:0] a);
    ce_lo();
    avr_wr({6'd0, inc, rd});
    for (int i = 0; i < 3; i++) avr_wr(a[8*i +: 8]);
  endtask

  task automatic wr_txn(input logic [23:0] a, input bit inc, input int nw,
                        input logic [15:0] d0, input bit rnd, input int cyc);
    logic [15:0] w;
    send_hdr(1'b0, inc, a);
    for (int i = 0; i < nw; i++) begin
      w = rnd ? 16'($urandom) : d0;
      avr_wr(w[7:0]);
      avr_wr(w[15:8]);
      wait_rdy("wr");
      exp_push(1'b1, 1'b0, inc ? 24'(a + 24'(i)) : a, w, cyc);
    end
    ce_hi();
    cmp_ev("wr");
  endtask

  task automatic rd_txn(input logic [23:0] a, input bit inc, input int nw,
                        input int cyc, input bit poke);
    logic [23:0] ea;
    logic [15:0] w;
    logic [7:0]  got;
    send_hdr(1'b1, inc, a);
    for (int i = 0; i < nw; i++) begin
      wait_rdy("rd");
      ea = inc ? 24'(a + 24'(i)) : a;
      w  = rd_fn(ea);
      for (int b = 0; b < 2; b++) begin
        avr_rd(got);
        chk_val("rd_byte", 32'(got), 32'(w[8*b +: 8]));
        if (poke && i == 0 && b == 0) begin
          tb_dat = 8'h3C; tb_oe = 1'b1;
          wclk(1);
          chk_val("bus_free", 32'(dap_data), 32'h3C);
          tb_oe = 1'b0;
          avr_wr(8'h77);
        end
      end
      if (inc || i == 0) exp_push(1'b0, 1'b0, ea, 16'd0, cyc);
    end
    if (inc) exp_push(1'b0, 1'b0, 24'(a + 24'(nw)), 16'd0, cyc);
    wait_rdy("rd_end");
    ce_hi();
    cmp_ev("rd");
  endtask

  initial begin
    logic [23:0] ra;
    bit          rd, inc;
    int          nw;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; dap_ce_n = 1'b1; dap_we_n = 1'b1; dap_re_n = 1'b1;
    tb_oe = 1'b0; tb_dat = 8'h00;
    ack_tied = 1'b1; rand_dly = 1'b0; ack_delay = 0;

    // Reset state
    wclk(3);
    chk_val("rst_rnb",  32'(dap_r_n_b), 32'd1);
    chk_val("rst_wrq",  32'(w_rq), 32'd0);
    chk_val("rst_rrq",  32'(r_rq), 32'd0);
    chk_val("rst_err",  32'(err), 32'd0);
    chk_val("rst_addr", 32'(addr), 32'd0);
    chk_val("rst_dwr",  32'(d_wr), 32'd0);
    tb_dat = 8'hA5; tb_oe = 1'b1; wclk(1);
    chk_val("rst_bus_free", 32'(dap_data), 32'hA5);
    tb_oe = 1'b0;
    rst_n = 1'b1;
    wclk(3);

    // Auto-increment write, zero-wait target
    wr_txn(24'h543210, 1'b1, 2, 16'hABCD, 1'b0, 1);
    // Plain read of 0x000100, with an ignored write strobe in RDAT
    rd_txn(24'h000100, 1'b0, 1, 1, 1'b1);

    // Backpressure: ack withheld 20 cycles
    ack_tied = 1'b0; ack_delay = 20;
    wr_txn(24'h00A5A5, 1'b0, 1, 16'h1234, 1'b0, 21);
    ack_tied = 1'b1; ack_delay = 0;

    // Deselect mid-data: no request, then a normal transaction
    send_hdr(1'b0, 1'b0, 24'h123456);
    avr_wr(8'h99);
    ce_hi();
    cmp_ev("abort");
    wr_txn(24'h123456, 1'b0, 1, 16'h5AA5, 1'b0, 1);

    // Address wrap on auto-increment
    wr_txn(24'hFFFFFF, 1'b1, 2, 16'h0F0F, 1'b1, 1);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      rd  = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 3);
      ra  = ($urandom_range(0, 3) == 0) ? 24'(24'hFFFFFF - 24'($urandom_range(0, 2)))
                                       : 24'($urandom);
      ack_tied  = 1'($urandom_range(0, 1));
      rand_dly  = !ack_tied;
      ack_delay = ack_tied ? 0 : $urandom_range(0, 4);
      if (rd) rd_txn(ra, inc, nw, ack_tied ? 1 : 0, 1'b0);
      else    wr_txn(ra, inc, nw, 16'd0, 1'b1, ack_tied ? 1 : 0);
    end
    rand_dly = 1'b0;

    // Timeout: target never acks
    ack_tied = 1'b0; ack_delay = 1 << 20;
    send_hdr(1'b0, 1'b0, 24'h0BCDEF);
    avr_wr(8'h11);
    avr_wr(8'h22);
    wclk(300);
    chk_val("tmo_err", 32'(err), 32'd1);
    chk_val("tmo_wrq", 32'(w_rq), 32'd0);
    chk_val("tmo_rnb", 32'(dap_r_n_b), 32'd1);
    avr_wr(8'h00);
    avr_wr(8'h33);
    exp_push(1'b1, 1'b1, 24'h0BCDEF, 16'h2211, TMO_CYC);
    ce_hi();
    cmp_ev("tmo");
    ack_tied = 1'b1; ack_delay = 0;
    wr_txn(24'h000042, 1'b0, 1, 16'h4242, 1'b0, 1);
    chk_val("err_sticky", 32'(err), 32'd1);

    // Reset while a request is pending
    ack_tied = 1'b0; ack_delay = 1 << 20;
    send_hdr(1'b0, 1'b0, 24'h00BEAD);
    avr_wr(8'h44);
    avr_wr(8'h55);
    chk_val("rstq_pre_wrq", 32'(w_rq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("rstq_wrq",  32'(w_rq), 32'd0);
    chk_val("rstq_addr", 32'(addr), 32'd0);
    chk_val("rstq_dwr",  32'(d_wr), 32'd0);
    chk_val("rstq_err",  32'(err), 32'd0);
    chk_val("rstq_rnb",  32'(dap_r_n_b), 32'd1);
    dap_ce_n = 1'b1;
    wclk(3);
    rst_n = 1'b1;
    exp_push(1'b1, 1'b1, 24'h00BEAD, 16'h5544, 0);
    cmp_ev("rstq");
    ack_tied = 1'b1; ack_delay = 0;
    rd_txn(24'h000777, 1'b1, 2, 1, 1'b0);

    chk_val("req_stable", 32'(stab_bad), 32'd0);
    chk_val("rnb_track",  32'(rnb_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
